// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: streams host words into a LUT configuration chain with optional readback.
// Define LUT_CFG_READBACK_EN to capture words displaced from the chain onto rd_valid/rd_data.
module lut_cfg_loader #(
    parameter int CONFIG_WIDTH = 8,
    parameter int CHAIN_WORDS  = 4
) (
    input  logic                    config_clk,
    input  logic                    config_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [CONFIG_WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    cfg_en,
    output logic [CONFIG_WIDTH-1:0] cfg_data,
    input  logic [CONFIG_WIDTH-1:0] cfg_ret,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic                    rd_valid,
    output logic [CONFIG_WIDTH-1:0] rd_data
);
    localparam int CW = (CHAIN_WORDS > 1) ? $clog2(CHAIN_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHAIN_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    cfg_en_q, cfg_en_d;
    logic [CONFIG_WIDTH-1:0] cfg_data_q, cfg_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic                    accept, last;

    assign in_ready = (state_q == LOAD);
    // abort wins over a same-cycle word
    assign accept   = in_ready && in_valid && !abort;
    assign last     = (cnt_q == LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        aborted_d  = aborted_q;
        cfg_en_d   = accept;
        cfg_data_d = accept ? in_data : cfg_data_q;
        done_d     = accept && last;
        case (state_q)
            IDLE: if (start) begin
                state_d   = LOAD;
                cnt_d     = '0;
                aborted_d = 1'b0;
            end
            LOAD: if (abort) begin
                state_d   = IDLE;
                aborted_d = 1'b1;
            end else if (accept) begin
                state_d = last ? FIN : LOAD;
                cnt_d   = last ? cnt_q : cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cfg_en_q   <= 1'b0;
            cfg_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cfg_en_q   <= cfg_en_d;
            cfg_data_q <= cfg_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign cfg_en   = cfg_en_q;
    assign cfg_data = cfg_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;

`ifdef LUT_CFG_READBACK_EN
    logic                    rd_valid_q, rd_valid_d;
    logic [CONFIG_WIDTH-1:0] rd_data_q, rd_data_d;

    // the chain shifts on every cfg_en edge, so its output word is the one being displaced
    always_comb begin
        rd_valid_d = cfg_en_q;
        rd_data_d  = cfg_en_q ? cfg_ret : rd_data_q;
    end

    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`else
    logic unused_cfg_ret;
    assign unused_cfg_ret = ^cfg_ret;
    assign rd_valid       = 1'b0;
    assign rd_data        = '0;
`endif
endmodule

// File: doc/lut_cfg_loader.md
LUT_CFG_LOADER -- requirements
Module: lut_cfg_loader

Interface
REQ-001 SHALL have parameter CONFIG_WIDTH, default 8, giving the width of a configuration word.
REQ-002 SHALL have parameter CHAIN_WORDS, default 4, giving the words per full load (one S44 cell = two LUT4 x 16 bits / 8).
REQ-003 SHALL have port config_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port config_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a load.
REQ-006 SHALL have port abort, input, 1 bit: cancel a load in progress.
REQ-007 SHALL have port in_valid, input, 1 bit: the host word on in_data is valid.
REQ-008 SHALL have port in_data, input, CONFIG_WIDTH bits: host configuration word.
REQ-009 SHALL have port in_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-010 SHALL have port cfg_en, output, 1 bit: drives the chain's config_en.
REQ-011 SHALL have port cfg_data, output, CONFIG_WIDTH bits: drives the chain's config_in.
REQ-012 SHALL have port cfg_ret, input, CONFIG_WIDTH bits: the chain's config_out, returned to the loader.
REQ-013 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a load completes.
REQ-015 SHALL have port aborted, output, 1 bit: sticky flag set when the last load was cancelled.
REQ-016 SHALL have port rd_valid, output, 1 bit: a readback word is present.
REQ-017 SHALL have port rd_data, output, CONFIG_WIDTH bits: readback word.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD and FIN.
REQ-019 IDLE: start=1 SHALL move to LOAD, clear the word counter to 0 and clear aborted.
REQ-020 LOAD: in_ready SHALL be 1, combinationally; in all other states in_ready SHALL be 0.
REQ-021 A word SHALL be accepted on a cycle with in_valid=1 and in_ready=1.
REQ-022 On an accepted word, the next cycle SHALL present cfg_en=1 and cfg_data=in_data from registers, giving a latency of 1.
REQ-023 On cycles with no accepted word, cfg_en SHALL be 0 the next cycle and cfg_data SHALL hold its last value.
REQ-024 Each accepted word SHALL increment the counter; the counter width SHALL be clog2(CHAIN_WORDS) with a minimum of 1.
REQ-025 Accepting word number CHAIN_WORDS-1 SHALL move LOAD to FIN; the counter SHALL not wrap within a load.
REQ-026 FIN SHALL last exactly one cycle, during which done=1 (this coincides with the final cfg_en pulse), then SHALL return to IDLE.
REQ-027 busy SHALL be 1 in LOAD and FIN and 0 in IDLE.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 abort in LOAD SHALL take priority over a same-cycle accept: the word is not accepted, no cfg_en pulse follows, the FSM returns to IDLE and aborted=1.
REQ-030 abort in IDLE or FIN SHALL be ignored.
REQ-031 start and abort asserted together in IDLE SHALL be treated as start.
REQ-032 in_valid=0 stalls in LOAD SHALL be of unbounded length and SHALL have no timeout.

Reset
REQ-033 config_rst=1 SHALL asynchronously force IDLE, counter=0, cfg_en=0, cfg_data=0, done=0, busy=0, aborted=0, rd_valid=0 and rd_data=0.
REQ-034 Reset during LOAD SHALL discard the partial load without emitting a done pulse; chain contents are then undefined and the host must reload.
REQ-035 Reset deassertion SHALL be usable on any cycle; the first start is honoured on the first edge after deassertion.

Configuration
REQ-036 The macro LUT_CFG_READBACK_EN SHALL enable readback.
REQ-037 When LUT_CFG_READBACK_EN is defined, on every edge where cfg_en=1, cfg_ret SHALL be captured into rd_data with rd_valid=1 for the following cycle (the word displaced from the chain, oldest first).
REQ-038 When LUT_CFG_READBACK_EN is defined, a full load SHALL return exactly CHAIN_WORDS readback words, in the order they were loaded in the previous load.
REQ-039 When LUT_CFG_READBACK_EN is undefined, rd_valid and rd_data SHALL be constant 0, no capture registers SHALL exist, and cfg_ret SHALL be unused.

Verification
REQ-040 Reset, start, then 4 back-to-back words 0x11, 0x22, 0x33, 0x44 -> cfg_en high for 4 consecutive cycles, one cycle after each accept, cfg_data in the same order, done exactly once, coinciding with the 0x44 cfg_en pulse.
REQ-041 Same load with in_valid low for 3 cycles between each word -> identical cfg_data sequence, no spurious cfg_en, busy held high throughout.
REQ-042 Start, accept 2 words, then abort together with in_valid=1 -> exactly 2 cfg_en pulses, aborted=1, busy=0 the next cycle, no done; a following start clears aborted.
REQ-043 start pulsed during LOAD, and start+abort asserted together in IDLE -> the first is ignored; the second starts a load with aborted=0.
REQ-044 config_rst asserted mid-load after word 2 -> all outputs 0 immediately (asynchronously), no done; a fresh 4-word load then completes normally.
REQ-045 With LUT_CFG_READBACK_EN and the chain modelled as a 4-deep shift register: load A1..A4, then load B1..B4 -> the second load yields rd_valid 4 times with rd_data A1, A2, A3, A4; without the macro, rd_valid stays 0.
